// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared constants and helpers for the data-RAM arbiter slice. The RAM
// instance and the arbiter take their geometry from the same constants so
// they cannot drift apart.
//   MEM_ADDR_W  : RAM word address width (256 words)
//   MEM_DATA_W  : RAM data width
//   RD_LAT_MAX  : deepest RAM read latency the owner pipeline supports
//   owner_e     : which requester issued an access (A = CPU, B = debug)
package ram_arbiter_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 32;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    // The port that should win the next conflict after 'o' was granted.
    function automatic owner_e other_port(input owner_e o);
        return (o == OWNER_A) ? OWNER_B : OWNER_A;
    endfunction

    // Keeps the owner pipeline depth inside the supported 1..RD_LAT_MAX
    // window even if an out-of-range latency is configured.
    function automatic int lat_depth(input int lat);
        if (lat < 1) begin
            return 1;
        end
        if (lat > RD_LAT_MAX) begin
            return RD_LAT_MAX;
        end
        return lat;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
// Bundles both requester ports and the RAM-side port of the arbiter.
//   a_* / b_*  : request (req, we, addr, wdata), grant, read response
//   ram_*      : access strobe, write enable, address, write data, read data
// Modports:
//   master : the surroundings (requesters and the RAM instance)
//   slave  : the arbiter itself
interface ram_arbiter_if #(
    parameter int ADDR_W = ram_arbiter_pkg::MEM_ADDR_W,
    parameter int DATA_W = ram_arbiter_pkg::MEM_DATA_W
);

    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

endinterface

// File: rtl/ram_arbiter_rd_owner_pipe.sv
// rd_owner_pipe
// RD_LAT-deep shift register of {valid, owner}. One entry is pushed every
// cycle: a read grant pushes {1, winner}, anything else pushes {0, x}. The
// tail lines up with the cycle the RAM presents the read data, so it tells
// the arbiter which port the current ram_rdata belongs to.
//   clk        : clock
//   rst        : synchronous active-high reset, clears all valid bits
//   push_vld   : a read was granted this cycle
//   push_owner : port that was granted
//   tail_vld   : ram_rdata in this cycle answers a granted read
//   tail_owner : port that issued that read
module rd_owner_pipe
    import ram_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_vld,
    input  owner_e push_owner,
    output logic   tail_vld,
    output owner_e tail_owner
);

    localparam int DEPTH = lat_depth(RD_LAT);

    logic [DEPTH-1:0] vld_p;
    owner_e           owner_p [DEPTH];

    // Valid bits are the only routing state that must be cleared; a stale
    // owner behind a cleared valid bit is never looked at.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= push_vld;
            for (int i = DEPTH - 1; i > 0; i--) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        owner_p[0] <= push_owner;
        for (int i = DEPTH - 1; i > 0; i--) begin
            owner_p[i] <= owner_p[i-1];
        end
    end

    // Tail stage: aligned with RAM read data
    assign tail_vld   = vld_p[DEPTH-1];
    assign tail_owner = owner_p[DEPTH-1];

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares the single-port data RAM between the CPU load/store path (port A)
// and the debug/loader path (port B). At most one access is issued per
// cycle; the grant is combinational from the requests and the round-robin
// pointer. Read data is routed back to the issuing port RD_LAT cycles after
// its grant by the rd_owner_pipe sub-module.
//   clk_25mhz : system clock
//   reset     : synchronous active-high reset
//   bus       : requester ports A/B and the RAM-side port (slave modport)
// Parameters:
//   ADDR_W, DATA_W : RAM geometry
//   RD_LAT         : RAM read latency in cycles (1..4)
//   FIXED_PRIO_A   : 1 = A always wins a conflict, pointer ignored
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int RD_LAT       = 1,
    parameter int FIXED_PRIO_A = 0
) (
    input logic         clk_25mhz,
    input logic         reset,
    ram_arbiter_if.slave bus
);

    localparam logic ROUND_ROBIN = (FIXED_PRIO_A == 0);

    // Port that wins the next conflict.
    owner_e prio;

    logic              prio_b;
    logic              win_a;
    logic              win_b;
    logic              gnt_a;
    logic              gnt_b;
    logic              grant;
    owner_e            winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              tail_vld;
    owner_e            tail_owner;
    logic              rvalid_a;
    logic              rvalid_b;

    // Selection: a lone requester always wins; on conflict the pointer
    // decides. Reset masks the grants so nothing reaches the RAM.
    assign prio_b = ROUND_ROBIN && (prio == OWNER_B);
    assign win_b  = bus.b_req && (!bus.a_req || prio_b);
    assign win_a  = bus.a_req && !win_b;
    assign gnt_a  = win_a && !reset;
    assign gnt_b  = win_b && !reset;
    assign grant  = gnt_a || gnt_b;
    assign winner = win_b ? OWNER_B : OWNER_A;

    assign sel_we    = win_b ? bus.b_we    : bus.a_we;
    assign sel_addr  = win_b ? bus.b_addr  : bus.a_addr;
    assign sel_wdata = win_b ? bus.b_wdata : bus.a_wdata;

    assign bus.a_gnt     = gnt_a;
    assign bus.b_gnt     = gnt_b;
    assign bus.ram_en    = grant;
    assign bus.ram_we    = grant && sel_we;
    assign bus.ram_addr  = sel_addr;
    assign bus.ram_wdata = sel_wdata;

    // The pointer moves on every grant, contended or not, so the port that
    // was just served always loses the next conflict.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            prio <= OWNER_A;
        end else if (grant && ROUND_ROBIN) begin
            prio <= other_port(winner);
        end
    end

    rd_owner_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_owner_pipe (
        .clk        (clk_25mhz),
        .rst        (reset),
        .push_vld   (grant && !sel_we),
        .push_owner (winner),
        .tail_vld   (tail_vld),
        .tail_owner (tail_owner)
    );

    // Response routing: the tail entry names the owner of ram_rdata. Reset
    // also masks the tail so a read in flight never answers during reset.
    assign rvalid_a = tail_vld && (tail_owner == OWNER_A) && !reset;
    assign rvalid_b = tail_vld && (tail_owner == OWNER_B) && !reset;

    assign bus.a_rvalid = rvalid_a;
    assign bus.b_rvalid = rvalid_b;
    assign bus.a_rdata  = rvalid_a ? bus.ram_rdata : '0;
    assign bus.b_rdata  = rvalid_b ? bus.ram_rdata : '0;

endmodule
